// File: rtl/ap_mult_share_arb.sv
// Round-robin arbiter and issue sequencer that shares one external combinational
// multiplier among NUM_REQ requesters and returns tagged products after MUL_LAT+1 cycles.
module ap_mult_share_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MUL_LAT = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [WIDTH-1:0]             mul_a_o,
   output logic [WIDTH-1:0]             mul_b_o,
   input  logic [2*WIDTH-1:0]           mul_p_i,
   output logic                         resp_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]   resp_id_o,
   output logic [2*WIDTH-1:0]           resp_p_o,
   output logic                         busy_o,
   output logic [15:0]                  issue_cnt_o
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned CW   = ID_W + 1;
   localparam int unsigned PW   = 2 * WIDTH;

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic             s0_valid_q, s0_valid_d;
   logic [ID_W-1:0]  s0_id_q, s0_id_d;
   logic [15:0]      issue_cnt_q, issue_cnt_d;

   logic [MUL_LAT-1:0] pv_q;
   logic [ID_W-1:0]    pid_q [MUL_LAT];
   logic [PW-1:0]      pp_q  [MUL_LAT];

   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [CW-1:0]    cand;
   logic             accept;

   // Search from rr_ptr upward, wrapping modulo NUM_REQ, for the first valid requester.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = CW'(rr_ptr_q) + CW'(k);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   assign accept = en_i & grant_found;

   always_comb begin
      req_ready_o = '0;
      if (accept) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   // Issue stage next state: operands and pointer only move on an accept.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      s0_valid_d  = 1'b0;
      s0_id_d     = s0_id_q;
      issue_cnt_d = issue_cnt_q;
      if (accept) begin
         rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         mul_a_d     = req_a_i[grant_idx*WIDTH +: WIDTH];
         mul_b_d     = req_b_i[grant_idx*WIDTH +: WIDTH];
         s0_valid_d  = 1'b1;
         s0_id_d     = grant_idx;
         issue_cnt_d = issue_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q    <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         s0_valid_q  <= 1'b0;
         s0_id_q     <= '0;
         issue_cnt_q <= '0;
         pv_q        <= '0;
         for (int unsigned s = 0; s < MUL_LAT; s++) begin
            pid_q[s] <= '0;
            pp_q[s]  <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         s0_valid_q  <= s0_valid_d;
         s0_id_q     <= s0_id_d;
         issue_cnt_q <= issue_cnt_d;
         // Result pipeline shifts unconditionally; only the valid bit marks real products.
         pv_q[0]  <= s0_valid_q;
         pid_q[0] <= s0_id_q;
         pp_q[0]  <= mul_p_i;
         for (int unsigned s = 1; s < MUL_LAT; s++) begin
            pv_q[s]  <= pv_q[s-1];
            pid_q[s] <= pid_q[s-1];
            pp_q[s]  <= pp_q[s-1];
         end
      end
   end

   assign mul_a_o      = mul_a_q;
   assign mul_b_o      = mul_b_q;
   assign resp_valid_o = pv_q[MUL_LAT-1];
   assign resp_id_o    = pid_q[MUL_LAT-1];
   assign resp_p_o     = pp_q[MUL_LAT-1];
   assign busy_o       = s0_valid_q | (|pv_q);
   assign issue_cnt_o  = issue_cnt_q;

endmodule

// File: tb/tb_ap_mult_share_arb.sv
// Bench for ap_mult_share_arb: two instances (MUL_LAT=1 and 3) share stimulus and are
// compared each cycle against an accept-history model of grants, counts and responses.
module tb_ap_mult_share_arb;

   localparam int unsigned NR  = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned IDW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, en;
   logic [NR-1:0]   req_valid;
   logic [NR*W-1:0] req_a, req_b;

   logic [NR-1:0]   rdy1, rdy3;
   logic [W-1:0]    ma1, mb1, ma3, mb3;
   logic [2*W-1:0]  mp1, mp3, rp1, rp3;
   logic            rv1, rv3, busy1, busy3;
   logic [IDW-1:0]  rid1, rid3;
   logic [15:0]     cnt1, cnt3;

   assign mp1 = 16'(ma1) * 16'(mb1);
   assign mp3 = 16'(ma3) * 16'(mb3);

   ap_mult_share_arb #(.NUM_REQ(NR), .WIDTH(W), .MUL_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_valid_i(req_valid),
      .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(rdy1),
      .mul_a_o(ma1), .mul_b_o(mb1), .mul_p_i(mp1),
      .resp_valid_o(rv1), .resp_id_o(rid1), .resp_p_o(rp1),
      .busy_o(busy1), .issue_cnt_o(cnt1)
   );

   ap_mult_share_arb #(.NUM_REQ(NR), .WIDTH(W), .MUL_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_valid_i(req_valid),
      .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(rdy3),
      .mul_a_o(ma3), .mul_b_o(mb3), .mul_p_i(mp3),
      .resp_valid_o(rv3), .resp_id_o(rid3), .resp_p_o(rp3),
      .busy_o(busy3), .issue_cnt_o(cnt3)
   );

   int          cyc = 0;
   bit          chk_on = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          m_rr = 0;
   int          m_cnt = 0;
   logic [7:0]  m_a = '0;
   logic [7:0]  m_b = '0;
   int          flush_upto = -1000;
   bit          hv  [int];
   int          hid [int];
   int          hp  [int];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Response due in cycle c comes from the accept made in cycle c-1-lat, unless a reset flushed it.
   task automatic exp_resp(input int c, input int lat, output bit v, output int id, output int p);
      int k;
      k  = c - 1 - lat;
      v  = (k > flush_upto) && hv.exists(k);
      id = v ? hid[k] : 0;
      p  = v ? hp[k] : 0;
   endtask

   function automatic bit exp_busy(input int c, input int lat);
      for (int k = c - 1 - lat; k <= c - 1; k++) begin
         if (k > flush_upto && hv.exists(k)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Check this cycle's outputs, advance the model across the coming edge, then step one clock.
   task automatic cycle();
      int            w;
      logic [NR-1:0] exp_rdy;
      bit            v;
      int            id, p;
      #1;
      w = -1;
      for (int k = 0; k < int'(NR); k++) begin
         int j;
         j = (m_rr + k) % int'(NR);
         if (w < 0 && req_valid[j]) w = j;
      end
      exp_rdy = '0;
      if (en && w >= 0) exp_rdy[w] = 1'b1;
      if (chk_on) begin
         chk("req_ready_L1", 32'(rdy1), 32'(exp_rdy));
         chk("req_ready_L3", 32'(rdy3), 32'(exp_rdy));
         chk("issue_cnt_L1", 32'(cnt1), 32'(m_cnt));
         chk("issue_cnt_L3", 32'(cnt3), 32'(m_cnt));
         chk("mul_a", 32'(ma1), 32'(m_a));
         chk("mul_b", 32'(mb3), 32'(m_b));
         exp_resp(cyc, 1, v, id, p);
         chk("resp_valid_L1", 32'(rv1), 32'(v));
         if (v) begin
            chk("resp_id_L1", 32'(rid1), 32'(id));
            chk("resp_p_L1", 32'(rp1), 32'(p));
         end
         chk("busy_L1", 32'(busy1), 32'(exp_busy(cyc, 1)));
         exp_resp(cyc, 3, v, id, p);
         chk("resp_valid_L3", 32'(rv3), 32'(v));
         if (v) begin
            chk("resp_id_L3", 32'(rid3), 32'(id));
            chk("resp_p_L3", 32'(rp3), 32'(p));
         end
         chk("busy_L3", 32'(busy3), 32'(exp_busy(cyc, 3)));
      end
      if (rst) begin
         m_rr       = 0;
         m_cnt      = 0;
         m_a        = '0;
         m_b        = '0;
         flush_upto = cyc;
      end else if (en && w >= 0) begin
         hv[cyc]  = 1'b1;
         hid[cyc] = w;
         hp[cyc]  = int'(req_a[w*W +: W]) * int'(req_b[w*W +: W]);
         m_a      = req_a[w*W +: W];
         m_b      = req_b[w*W +: W];
         m_rr     = (w + 1) % int'(NR);
         m_cnt    = (m_cnt + 1) % 65536;
      end
      if (hv.exists(cyc - 10)) begin
         hv.delete(cyc - 10);
         hid.delete(cyc - 10);
         hp.delete(cyc - 10);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      cycle();
      chk_on = 1'b1;
      cycle();
      rst = 1'b0; en = 1'b1;
      cycle();

      // Single request from requester 2
      req_valid = 4'b0100;
      req_a = 32'h000F_0000;
      req_b = 32'h0011_0000;
      #1 chk("single_ready", 32'(rdy1), 32'h4);
      cycle();
      req_valid = '0;
      for (int k = 1; k <= 6; k++) begin
         if (k == 2) begin
            #1;
            chk("single_rv_L1", 32'(rv1), 32'h1);
            chk("single_id_L1", 32'(rid1), 32'h2);
            chk("single_p_L1", 32'(rp1), 32'h00FF);
         end
         if (k == 4) begin
            #1;
            chk("single_rv_L3", 32'(rv3), 32'h1);
            chk("single_p_L3", 32'(rp3), 32'h00FF);
         end
         cycle();
      end
      chk("single_cnt", 32'(cnt1), 32'h1);
      chk("single_busy", 32'(busy3), 32'h0);

      // Full contention from a fresh pointer
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req_valid = 4'hF;
      req_a = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b = {4{8'd3}};
      for (int k = 0; k < 8; k++) begin
         #1 chk("cont_grant", 32'(rdy1), 32'(1 << (k % 4)));
         if (k >= 2) begin
            chk("cont_rv", 32'(rv1), 32'h1);
            chk("cont_prod", 32'(rp1), 32'(3 * ((k - 2) % 4 + 1)));
         end
         cycle();
      end

      // Gating with requests still pending, then resume
      en = 1'b0;
      #1 chk("gate_ready", 32'(rdy1), 32'h0);
      for (int k = 0; k < 6; k++) cycle();
      en = 1'b1;
      for (int k = 0; k < 4; k++) cycle();

      // Reset in the cycle after an accept
      req_valid = 4'b0010;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rstmid_rv_L1", 32'(rv1), 32'h0);
         chk("rstmid_rv_L3", 32'(rv3), 32'h0);
         cycle();
      end
      chk("rstmid_cnt", 32'(cnt1), 32'h0);
      chk("rstmid_resp_p", 32'(rp3), 32'h0);

      // Randomized traffic with occasional gating and reset
      for (int k = 0; k < 400; k++) begin
         req_valid = NR'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         en        = ($urandom_range(0, 9) != 0);
         rst       = ($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 1'b0; en = 1'b1; req_valid = '0;
      for (int k = 0; k < 6; k++) cycle();

      // Counter wrap after exactly 65536 accepts
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req_valid = 4'hF;
      for (int k = 0; k < 65536; k++) begin
         req_a = $urandom;
         req_b = $urandom;
         cycle();
      end
      req_valid = '0;
      #1;
      chk("wrap_cnt_L1", 32'(cnt1), 32'h0);
      chk("wrap_cnt_L3", 32'(cnt3), 32'h0);
      for (int k = 0; k < 6; k++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
